// File: rtl/dense_layer_ctrl_if.sv
// Bus bundle between the dense-layer sequencer and its surroundings:
// layer request, weight/bias ROM ports, single-neuron unit, result stream.
//
// Handshake semantics: there is no ready/backpressure anywhere on this bus.
// layer_start, neu_start, neu_done, out_valid and layer_done are one-cycle
// pulses; a pulse is consumed in the cycle it is high. ROM data (w_rdata,
// b_rdata) is valid exactly one cycle after the matching read enable.
interface dense_layer_ctrl_if #(
   parameter int N          = 16,
   parameter int NUM_INPUTS = 4,
   parameter int IDX_W      = 4,
   parameter int WA_W       = 8
);
   logic                    layer_start;
   logic [NUM_INPUTS*N-1:0] in_flat;
   logic [WA_W-1:0]         w_addr;
   logic                    w_ren;
   logic [N-1:0]            w_rdata;
   logic [IDX_W-1:0]        b_addr;
   logic                    b_ren;
   logic [N-1:0]            b_rdata;
   logic                    neu_start;
   logic [NUM_INPUTS*N-1:0] neu_in_flat;
   logic [NUM_INPUTS*N-1:0] neu_w_flat;
   logic [N-1:0]            neu_bias;
   logic [N-1:0]            neu_out;
   logic                    neu_done;
   logic                    out_valid;
   logic [IDX_W-1:0]        out_idx;
   logic [N-1:0]            out_data;
   logic                    layer_done;
   logic                    busy;

   // Sequencer side
   modport master (
      input  layer_start, in_flat, w_rdata, b_rdata, neu_out, neu_done,
      output w_addr, w_ren, b_addr, b_ren, neu_start, neu_in_flat,
             neu_w_flat, neu_bias, out_valid, out_idx, out_data,
             layer_done, busy
   );

   // Environment side: ROMs, neuron unit, producer and consumer
   modport slave (
      output layer_start, in_flat, w_rdata, b_rdata, neu_out, neu_done,
      input  w_addr, w_ren, b_addr, b_ren, neu_start, neu_in_flat,
             neu_w_flat, neu_bias, out_valid, out_idx, out_data,
             layer_done, busy
   );
endinterface

// File: rtl/dense_layer_ctrl.sv
// Dense-layer sequencer: latches one activation vector, then for every
// output neuron fetches weights and bias from ROM, starts the neuron unit,
// waits for its done and emits the (optionally rectified) result.
// Optional feature macro: DENSE_CTRL_RELU_EN (ReLU on out_data).
// state_dbg exposes the FSM state for observation.
module dense_layer_ctrl #(
   parameter int N           = 16,
   parameter int Q           = 8,
   parameter int NUM_INPUTS  = 4,
   parameter int NUM_OUTPUTS = 10,
   parameter int IDX_W       = 4,
   parameter int WA_W        = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   dense_layer_ctrl_if.master   bus,
   output logic [1:0]           state_dbg
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT} state_t;

   localparam int               CNT_W  = $clog2(NUM_INPUTS + 1);
   localparam logic [CNT_W-1:0] K_LAST = CNT_W'(NUM_INPUTS);
   localparam logic [IDX_W-1:0] N_LAST = IDX_W'(NUM_OUTPUTS - 1);
   localparam logic [WA_W-1:0]  NI_W   = WA_W'(NUM_INPUTS);

   state_t                  state, state_nx;
   logic [IDX_W-1:0]        neuron;
   logic [CNT_W-1:0]        fcnt;
   logic [NUM_INPUTS*N-1:0] in_r;
   logic [NUM_INPUTS*N-1:0] w_r;
   logic [N-1:0]            bias_r;
   logic                    out_valid_r;
   logic [IDX_W-1:0]        out_idx_r;
   logic [N-1:0]            out_data_r;
   logic                    layer_done_r;

   logic                    w_ren_c;
   logic [WA_W-1:0]         w_addr_c;
   logic                    b_ren_c;
   logic [IDX_W-1:0]        b_addr_c;
   logic                    neu_start_c;

   logic start_ok;
   logic done_ok;
   logic last_neuron;

   // A start is only accepted while fully idle (busy also covers the
   // layer_done cycle, so a start in that cycle is dropped too).
   assign start_ok    = (state == S_IDLE) && bus.layer_start && !layer_done_r;
   assign done_ok     = (state == S_WAIT) && bus.neu_done;
   assign last_neuron = (neuron == N_LAST);

   // Output activation applied on the way into the out_data register.
   function automatic logic [N-1:0] act_fn(input logic [N-1:0] x);
`ifdef DENSE_CTRL_RELU_EN
      act_fn = x[N-1] ? '0 : x;
`else
      act_fn = x;
`endif
   endfunction

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start_ok) state_nx = S_FETCH;
         S_FETCH: if (fcnt == K_LAST) state_nx = S_ISSUE;
         S_ISSUE: state_nx = S_WAIT;
         S_WAIT:  if (bus.neu_done) state_nx = last_neuron ? S_IDLE : S_FETCH;
         default: state_nx = S_IDLE;
      endcase
   end

   // Moore outputs: ROM reads during FETCH, neuron start during ISSUE
   always_comb begin
      w_ren_c     = 1'b0;
      w_addr_c    = '0;
      b_ren_c     = 1'b0;
      b_addr_c    = '0;
      neu_start_c = 1'b0;
      case (state)
         S_FETCH: begin
            if (fcnt != K_LAST) begin
               w_ren_c  = 1'b1;
               w_addr_c = WA_W'(neuron) * NI_W + WA_W'(fcnt);
            end
            if (fcnt == '0) begin
               b_ren_c  = 1'b1;
               b_addr_c = neuron;
            end
         end
         S_ISSUE: neu_start_c = 1'b1;
         default: ;
      endcase
   end

   // Datapath: activation latch, ROM capture one cycle after each read,
   // neuron counter and the registered result pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         neuron       <= '0;
         fcnt         <= '0;
         in_r         <= '0;
         w_r          <= '0;
         bias_r       <= '0;
         out_valid_r  <= 1'b0;
         out_idx_r    <= '0;
         out_data_r   <= '0;
         layer_done_r <= 1'b0;
      end else begin
         out_valid_r  <= 1'b0;
         layer_done_r <= 1'b0;
         if (start_ok) begin
            in_r   <= bus.in_flat;
            neuron <= '0;
            fcnt   <= '0;
         end
         if (state == S_FETCH) begin
            for (int k = 0; k < NUM_INPUTS; k++) begin
               if (fcnt == CNT_W'(k + 1)) w_r[k*N +: N] <= bus.w_rdata;
            end
            if (fcnt == CNT_W'(1)) bias_r <= bus.b_rdata;
            fcnt <= (fcnt == K_LAST) ? '0 : fcnt + CNT_W'(1);
         end
         if (done_ok) begin
            out_valid_r  <= 1'b1;
            out_idx_r    <= neuron;
            out_data_r   <= act_fn(bus.neu_out);
            layer_done_r <= last_neuron;
            if (!last_neuron) neuron <= neuron + IDX_W'(1);
         end
      end
   end

   assign bus.w_ren       = w_ren_c;
   assign bus.w_addr      = w_addr_c;
   assign bus.b_ren       = b_ren_c;
   assign bus.b_addr      = b_addr_c;
   assign bus.neu_start   = neu_start_c;
   assign bus.neu_in_flat = in_r;
   assign bus.neu_w_flat  = w_r;
   assign bus.neu_bias    = bias_r;
   assign bus.out_valid   = out_valid_r;
   assign bus.out_idx     = out_idx_r;
   assign bus.out_data    = out_data_r;
   assign bus.layer_done  = layer_done_r;
   assign bus.busy        = (state != S_IDLE) || layer_done_r;
   assign state_dbg       = state;

endmodule

// File: tb/tb_dense_layer_ctrl.sv
// Self-checking bench for dense_layer_ctrl: ROM and neuron models, a
// scoreboard of expected results / ROM addresses, directed and random layers.
module tb_dense_layer_ctrl;

   localparam int N     = 16;
   localparam int Q     = 8;
   localparam int NI    = 4;
   localparam int NO    = 2;
   localparam int IDX_W = 4;
   localparam int WA_W  = 8;
   localparam int EW    = 1 + IDX_W + N;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] state_dbg;

   dense_layer_ctrl_if #(.N(N), .NUM_INPUTS(NI), .IDX_W(IDX_W), .WA_W(WA_W)) bus ();

   dense_layer_ctrl #(
      .N(N), .Q(Q), .NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .IDX_W(IDX_W), .WA_W(WA_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- bookkeeping ----------------
   int n_tests = 0;
   int n_fail  = 0;

   logic [EW-1:0]    exp_q[$];
   logic [WA_W-1:0]  exp_w_q[$];
   logic [IDX_W-1:0] exp_b_q[$];

   logic [N-1:0] wrom [NI*NO];
   logic [N-1:0] brom [NO];

   int   lat;
   int   start_cnt = 0;
   logic stray_done;
   logic chk_busy = 1'b0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [N-1:0] neuron_fn(input logic [NI*N-1:0] a,
                                              input logic [NI*N-1:0] w,
                                              input logic [N-1:0] b);
      int acc;
      logic signed [N-1:0] ak, wk;
      acc = int'($signed(b));
      for (int k = 0; k < NI; k++) begin
         ak  = a[k*N +: N];
         wk  = w[k*N +: N];
         acc = acc + ((int'(ak) * int'(wk)) >>> Q);
      end
      return acc[N-1:0];
   endfunction

   function automatic logic [N-1:0] act_exp(input logic [N-1:0] x);
`ifdef DENSE_CTRL_RELU_EN
      return ($signed(x) < 0) ? '0 : x;
`else
      return x;
`endif
   endfunction

   // ---------------- ROM models (1-cycle read latency) ----------------
   always @(posedge clk) begin
      if (bus.w_ren) bus.w_rdata <= wrom[int'(bus.w_addr)];
      if (bus.b_ren) bus.b_rdata <= brom[int'(bus.b_addr)];
   end

   // ---------------- neuron model ----------------
   logic                   neu_done_r = 1'b0;
   logic                   neu_active = 1'b0;
   int                     neu_cnt;
   logic [N-1:0]           neu_res;
   logic [2*NI*N+N-1:0]    snap;

   assign bus.neu_done = neu_done_r | stray_done;

   always @(posedge clk) begin
      neu_done_r <= 1'b0;
      if (reset) begin
         neu_active <= 1'b0;
      end else if (bus.neu_start) begin
         neu_active <= 1'b1;
         neu_cnt    <= lat;
         snap       <= {bus.neu_in_flat, bus.neu_w_flat, bus.neu_bias};
         neu_res    <= neuron_fn(bus.neu_in_flat, bus.neu_w_flat, bus.neu_bias);
      end else if (neu_active) begin
         if (neu_cnt == 0) begin
            neu_done_r  <= 1'b1;
            bus.neu_out <= neu_res;
            neu_active  <= 1'b0;
         end else begin
            neu_cnt <= neu_cnt - 1;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [EW-1:0]    e;
      logic [WA_W-1:0]  ew;
      logic [IDX_W-1:0] eb;
      if (reset) begin
         chk_busy = 1'b0;
      end else begin
         if (chk_busy) begin
            check("busy_fall", 256'(bus.busy), 256'(0));
            chk_busy = 1'b0;
         end
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_out_valid", 256'(bus.out_valid), 256'(0));
            end else begin
               e = exp_q.pop_front();
               check("out_idx",    256'(bus.out_idx),    256'(e[N+IDX_W-1:N]));
               check("out_data",   256'(bus.out_data),   256'(e[N-1:0]));
               check("layer_done", 256'(bus.layer_done), 256'(e[EW-1]));
               if (e[EW-1]) begin
                  check("busy_at_done", 256'(bus.busy), 256'(1));
                  chk_busy = 1'b1;
               end
            end
         end else if (bus.layer_done) begin
            check("lone_layer_done", 256'(bus.layer_done), 256'(0));
         end
         if (bus.w_ren) begin
            if (exp_w_q.size() == 0) check("spurious_w_ren", 256'(bus.w_ren), 256'(0));
            else begin
               ew = exp_w_q.pop_front();
               check("w_addr", 256'(bus.w_addr), 256'(ew));
            end
         end
         if (bus.b_ren) begin
            if (exp_b_q.size() == 0) check("spurious_b_ren", 256'(bus.b_ren), 256'(0));
            else begin
               eb = exp_b_q.pop_front();
               check("b_addr", 256'(bus.b_addr), 256'(eb));
            end
         end
         if (bus.neu_start) start_cnt++;
         if (neu_active)
            check("neu_hold", 256'({bus.neu_in_flat, bus.neu_w_flat, bus.neu_bias}), 256'(snap));
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic [NI*N-1:0] rand_vec();
      logic [NI*N-1:0] v;
      for (int k = 0; k < NI; k++) v[k*N +: N] = N'($urandom);
      return v;
   endfunction

   task automatic rand_roms();
      for (int i = 0; i < NI*NO; i++) wrom[i] = N'($urandom);
      for (int j = 0; j < NO; j++)    brom[j] = N'($urandom);
   endtask

   task automatic start_layer(input logic [NI*N-1:0] inv);
      logic [NI*N-1:0] wv;
      for (int j = 0; j < NO; j++) begin
         for (int k = 0; k < NI; k++) begin
            wv[k*N +: N] = wrom[j*NI + k];
            exp_w_q.push_back(WA_W'(j*NI + k));
         end
         exp_b_q.push_back(IDX_W'(j));
         exp_q.push_back({(j == NO-1), IDX_W'(j), act_exp(neuron_fn(inv, wv, brom[j]))});
      end
      @(negedge clk);
      bus.in_flat     = inv;
      bus.layer_start = 1'b1;
      @(negedge clk);
      bus.layer_start = 1'b0;
   endtask

   task automatic wait_idle();
      int c = 0;
      do begin
         @(negedge clk);
         c++;
      end while ((exp_q.size() != 0 || bus.busy) && c < 2000);
      check("layer_timeout", 256'(c < 2000), 256'(1));
   endtask

   task automatic wait_starts(input int target);
      int c = 0;
      while (start_cnt < target && c < 2000) begin
         @(negedge clk);
         c++;
      end
      check("start_timeout", 256'(c < 2000), 256'(1));
   endtask

   task automatic run_layer(input logic [NI*N-1:0] inv);
      int base;
      base = start_cnt;
      start_layer(inv);
      wait_idle();
      check("neu_start_count", 256'(start_cnt - base), 256'(NO));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_w_ren"},      256'(bus.w_ren),       256'(0));
      check({tag, "_w_addr"},     256'(bus.w_addr),      256'(0));
      check({tag, "_b_ren"},      256'(bus.b_ren),       256'(0));
      check({tag, "_b_addr"},     256'(bus.b_addr),      256'(0));
      check({tag, "_neu_start"},  256'(bus.neu_start),   256'(0));
      check({tag, "_neu_vec"},    256'({bus.neu_in_flat, bus.neu_w_flat, bus.neu_bias}), 256'(0));
      check({tag, "_out_valid"},  256'(bus.out_valid),   256'(0));
      check({tag, "_out_idx"},    256'(bus.out_idx),     256'(0));
      check({tag, "_out_data"},   256'(bus.out_data),    256'(0));
      check({tag, "_layer_done"}, 256'(bus.layer_done),  256'(0));
      check({tag, "_busy"},       256'(bus.busy),        256'(0));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int base;
      reset           = 1'b1;
      bus.layer_start = 1'b0;
      bus.in_flat     = '0;
      stray_done      = 1'b0;
      lat             = 2;
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;

      // Basic layer: 1.0 inputs; neuron 0 -> 3.0, neuron 1 -> -4.0
      for (int k = 0; k < NI; k++) begin
         wrom[k]      = 16'h0080;
         wrom[NI + k] = 16'hFF00;
      end
      brom[0] = 16'h0100;
      brom[1] = 16'h0000;
      lat = 3;
      run_layer({NI{16'h0100}});

      // Second start during WAIT of neuron 0 must be ignored
      rand_roms();
      lat  = 6;
      base = start_cnt;
      start_layer(rand_vec());
      wait_starts(base + 1);
      repeat (2) @(negedge clk);
      bus.in_flat     = rand_vec();
      bus.layer_start = 1'b1;
      @(negedge clk);
      bus.layer_start = 1'b0;
      wait_idle();
      check("ignored_start_count", 256'(start_cnt - base), 256'(NO));

      // Stray neu_done during FETCH of neuron 1 and while idle
      rand_roms();
      lat = 2;
      start_layer(rand_vec());
      begin
         int c = 0;
         while (!bus.out_valid && c < 200) begin
            @(negedge clk);
            c++;
         end
         check("first_valid_timeout", 256'(c < 200), 256'(1));
      end
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      wait_idle();
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      repeat (3) @(negedge clk);

      // Stall: neuron holds done off for 20 cycles
      rand_roms();
      lat = 20;
      run_layer(rand_vec());

      // Random layers
      repeat (20) begin
         rand_roms();
         lat = $urandom_range(0, 5);
         run_layer(rand_vec());
      end

      // Reset during WAIT of neuron 1, then a fresh layer
      rand_roms();
      lat  = 10;
      base = start_cnt;
      start_layer(rand_vec());
      wait_starts(base + 2);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check_zero("mid_reset");
      exp_q.delete();
      exp_w_q.delete();
      exp_b_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      rand_roms();
      lat = 1;
      run_layer(rand_vec());

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
